// File: rtl/ddr_arbiter_pkg.sv
// rtl/ddr_arbiter_pkg.sv - shared state encoding and burst-length helper for ddr_arbiter
package ddr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        READ,
        WRITE
    } arb_state_t;

    localparam int LEN_W = 16;

    // A zero burst length still moves one beat on the DDR side.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

endpackage

// File: rtl/ddr_arbiter_rr.sv
// rtl/ddr_arbiter_rr.sv - two-way round-robin pick between requesting ports
module ddr_arbiter_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic       owner
);

    always_comb begin
        owner = 1'b0;
        case (req)
            2'b10:   owner = 1'b1;
            2'b11:   owner = ~last;
            default: owner = 1'b0;
        endcase
    end

endmodule

// File: rtl/ddr_arbiter.sv
// rtl/ddr_arbiter.sv - burst-serialising two-port arbiter in front of the DDR3 Avalon port
module ddr_arbiter
    import ddr_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in0_rd,
    input  logic                    in0_wr,
    input  logic [ADDR_WIDTH-1:0]   in0_addr,
    input  logic [BURST_WIDTH-1:0]  in0_burstLength,
    input  logic [DATA_WIDTH/8-1:0] in0_mask,
    input  logic [DATA_WIDTH-1:0]   in0_din,
    output logic                    in0_waitReq,
    output logic                    in0_valid,
    output logic [DATA_WIDTH-1:0]   in0_dout,
    input  logic                    in1_rd,
    input  logic                    in1_wr,
    input  logic [ADDR_WIDTH-1:0]   in1_addr,
    input  logic [BURST_WIDTH-1:0]  in1_burstLength,
    input  logic [DATA_WIDTH/8-1:0] in1_mask,
    input  logic [DATA_WIDTH-1:0]   in1_din,
    output logic                    in1_waitReq,
    output logic                    in1_valid,
    output logic [DATA_WIDTH-1:0]   in1_dout,
    output logic                    ddr_rd,
    output logic                    ddr_wr,
    output logic [ADDR_WIDTH-1:0]   ddr_addr,
    output logic [BURST_WIDTH-1:0]  ddr_burstLength,
    output logic [DATA_WIDTH/8-1:0] ddr_mask,
    output logic [DATA_WIDTH-1:0]   ddr_din,
    input  logic                    ddr_waitReq,
    input  logic                    ddr_valid,
    input  logic [DATA_WIDTH-1:0]   ddr_dout
);

    localparam int LW = BURST_WIDTH + 1;

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [LW-1:0] beats_q, beats_d;
    logic [LW-1:0] len_q, len_d;

    logic [1:0] req;
    logic       rr_owner;

    logic                    own_rd;
    logic                    own_wr;
    logic [ADDR_WIDTH-1:0]   own_addr;
    logic [BURST_WIDTH-1:0]  own_bl;
    logic [DATA_WIDTH/8-1:0] own_mask;
    logic [DATA_WIDTH-1:0]   own_din;
    logic [LW-1:0]           own_len;
    logic                    own_wait;
    logic                    own_valid;

    assign req = {in1_rd | in1_wr, in0_rd | in0_wr};

    ddr_arbiter_rr u_rr (
        .req   (req),
        .last  (last_q),
        .owner (rr_owner)
    );

    // Every mux keys off the registered owner so grants cannot glitch mid-burst.
    assign own_rd   = owner_q ? in1_rd          : in0_rd;
    assign own_wr   = owner_q ? in1_wr          : in0_wr;
    assign own_addr = owner_q ? in1_addr        : in0_addr;
    assign own_bl   = owner_q ? in1_burstLength : in0_burstLength;
    assign own_mask = owner_q ? in1_mask        : in0_mask;
    assign own_din  = owner_q ? in1_din         : in0_din;
    assign own_len  = LW'(eff_len(LEN_W'(own_bl)));

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_d          = last_q;
        beats_d         = beats_q;
        len_d           = len_q;
        ddr_rd          = 1'b0;
        ddr_wr          = 1'b0;
        ddr_addr        = '0;
        ddr_burstLength = '0;
        ddr_mask        = '0;
        ddr_din         = '0;
        own_wait        = 1'b1;
        own_valid       = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = rr_owner;
                    state_d = CMD;
                end
            end
            CMD: begin
                ddr_wr          = own_wr;
                ddr_rd          = own_rd & ~own_wr;
                ddr_addr        = own_addr;
                ddr_burstLength = own_bl;
                ddr_mask        = own_mask;
                ddr_din         = own_din;
                own_wait        = ddr_waitReq;
                if (!(own_rd | own_wr)) begin
                    state_d = IDLE;
                end else if (!ddr_waitReq) begin
                    last_d = owner_q;
                    len_d  = own_len;
                    if (!own_wr) begin
                        state_d = READ;
                        beats_d = '0;
                    end else if (own_len == LW'(1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WRITE;
                        beats_d = LW'(1);
                    end
                end
            end
            READ: begin
                own_valid = ddr_valid;
                if (ddr_valid) begin
                    beats_d = beats_q + LW'(1);
                    if (beats_d == len_q) state_d = IDLE;
                end
            end
            WRITE: begin
                ddr_wr          = own_wr;
                ddr_addr        = own_addr;
                ddr_burstLength = own_bl;
                ddr_mask        = own_mask;
                ddr_din         = own_din;
                own_wait        = ddr_waitReq;
                if (own_wr && !ddr_waitReq) begin
                    beats_d = beats_q + LW'(1);
                    if (beats_d == len_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            beats_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beats_q <= beats_d;
            len_q   <= len_d;
        end
    end

    assign in0_waitReq = owner_q ? 1'b1 : own_wait;
    assign in1_waitReq = owner_q ? own_wait : 1'b1;
    assign in0_valid   = ~owner_q & own_valid;
    assign in1_valid   = owner_q & own_valid;
    assign in0_dout    = ddr_dout;
    assign in1_dout    = ddr_dout;

endmodule
